// File: rtl/fire4_pkg.sv
// Shared definitions for the fire4 squeeze output path.
// Contents:
//   FIRE4_WOUT   output map width/height of the fire4 squeeze layer
//   FIRE4_SQ_CH  squeeze channels per pixel
//   WIDTH        channel word width
//   ofm_wr_state_t  writer FSM states
package fire4_pkg;

  localparam int FIRE4_WOUT  = 32;
  localparam int FIRE4_SQ_CH = 32;
  localparam int WIDTH       = 16;

  typedef enum logic [1:0] {IDLE, WRITE, DONE} ofm_wr_state_t;

endpackage

// File: rtl/ofm_hold_reg.sv
// Capture register for one squeeze output pixel with indexed read-out.
// Ports:
//   clk   clock
//   load  capture every entry of d on this edge
//   d     DSP_NO channel words from the squeeze stage
//   sel   channel index to read out
//   q     hold[sel], combinational
// The storage is deliberately not reset: it is always loaded before
// it is read.
module ofm_hold_reg #(
  parameter int DSP_NO = 32,
  parameter int WIDTH  = 16,
  parameter int SEL_W  = $clog2(DSP_NO)
) (
  input  logic             clk,
  input  logic             load,
  input  logic [WIDTH-1:0] d [0:DSP_NO-1],
  input  logic [SEL_W-1:0] sel,
  output logic [WIDTH-1:0] q
);

  logic [DSP_NO-1:0][WIDTH-1:0] hold;

  always_ff @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < DSP_NO; i++) hold[i] <= d[i];
    end
  end

  assign q = hold[sel];

endmodule

// File: rtl/fire4_squeeze_ofm_writer.sv
// Serialises fire4 squeeze output pixels into the fire4 feature-map RAM.
// Each accepted pixel (DSP_NO channels) is captured and then written
// one channel word per cycle at address {pix_cnt, ch}. After the last
// pixel of the layer, ram_feedback is held high and fmap_ready pulses.
// Ports:
//   clk, rst              clock; asynchronous active-low reset
//   fire4_squeeze_sample  one-cycle strobe, ofm_in valid on same edge
//   ofm_in                DSP_NO channel words
//   clear                 re-arm from DONE to IDLE
//   ram_we/addr/wdata     registered RAM write port
//   ram_feedback          high while the layer is complete
//   fmap_ready            one-cycle pulse when the layer completes
//   overflow              sticky: a sample was dropped
module fire4_squeeze_ofm_writer
  import fire4_pkg::*;
#(
  parameter int WOUT   = fire4_pkg::FIRE4_WOUT,
  parameter int DSP_NO = fire4_pkg::FIRE4_SQ_CH,
  parameter int WIDTH  = fire4_pkg::WIDTH,
  parameter int ADDR_W = $clog2(WOUT**2*DSP_NO)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fire4_squeeze_sample,
  input  logic [WIDTH-1:0]  ofm_in [0:DSP_NO-1],
  input  logic              clear,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [WIDTH-1:0]  ram_wdata,
  output logic              ram_feedback,
  output logic              fmap_ready,
  output logic              overflow
);

  localparam int NPIX  = WOUT*WOUT;
  localparam int PIX_W = $clog2(NPIX) + 1;  // extra bit: never wraps
  localparam int CH_W  = $clog2(DSP_NO);

  ofm_wr_state_t state, state_nxt;

  logic [PIX_W-1:0] pix_cnt;
  logic [CH_W-1:0]  ch;
  logic             ch_last, pix_last;
  logic             accept, drop;
  logic [WIDTH-1:0] hold_q;

  logic              ram_we_d;
  logic [ADDR_W-1:0] ram_addr_d;
  logic              done_q;

  assign ch_last  = (ch == CH_W'(DSP_NO-1));
  assign pix_last = (pix_cnt == PIX_W'(NPIX-1));

  // A sample is taken when idle, or exactly on the last channel of a
  // pixel so back-to-back pixels stream without a bubble. A sample on the
  // last channel of the final pixel has nowhere to go and is dropped.
  always_comb begin
    accept = 1'b0;
    case (state)
      IDLE:    accept = fire4_squeeze_sample;
      WRITE:   accept = fire4_squeeze_sample && ch_last && !pix_last;
      default: accept = 1'b0;
    endcase
  end

  assign drop = fire4_squeeze_sample && !accept;

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (fire4_squeeze_sample) state_nxt = WRITE;
      WRITE: begin
        if (ch_last) begin
          if (accept)        state_nxt = WRITE;
          else if (pix_last) state_nxt = DONE;
          else               state_nxt = IDLE;
        end
      end
      DONE:    if (clear) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs (pre-register): one RAM word per WRITE cycle
  always_comb begin
    ram_we_d   = (state == WRITE);
    ram_addr_d = ADDR_W'({pix_cnt[PIX_W-2:0], ch});
  end

  // Channel / pixel counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ch      <= '0;
      pix_cnt <= '0;
    end else begin
      if (state == WRITE) begin
        ch <= ch + 1'b1;
        if (ch_last) pix_cnt <= pix_cnt + 1'b1;
      end
      if (accept) ch <= '0;
      if (state == DONE && clear) begin
        ch      <= '0;
        pix_cnt <= '0;
      end
    end
  end

  ofm_hold_reg #(
    .DSP_NO (DSP_NO),
    .WIDTH  (WIDTH),
    .SEL_W  (CH_W)
  ) u_hold (
    .clk  (clk),
    .load (accept),
    .d    (ofm_in),
    .sel  (ch),
    .q    (hold_q)
  );

  // Registered RAM port and status. done_q lags the DONE state by one
  // edge, so feedback/fmap_ready appear the cycle after the final write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      done_q     <= 1'b0;
      fmap_ready <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      ram_we     <= ram_we_d;
      ram_addr   <= ram_addr_d;
      ram_wdata  <= hold_q;
      done_q     <= (state == DONE);
      fmap_ready <= (state == DONE) && !done_q;
      if (drop) overflow <= 1'b1;
    end
  end

  assign ram_feedback = done_q;

endmodule

// File: tb/tb_fire4_squeeze_ofm_writer.sv
module tb_fire4_squeeze_ofm_writer;

  localparam int WOUT   = 2;
  localparam int DSP_NO = 4;
  localparam int WIDTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              sample = 1'b0;
  logic [WIDTH-1:0]  ofm [0:DSP_NO-1];
  logic              clear = 1'b0;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [WIDTH-1:0]  ram_wdata;
  logic              ram_feedback;
  logic              fmap_ready;
  logic              overflow;

  int checks = 0;
  int failures = 0;
  int wcount [0:15];

  always #5 clk = ~clk;

  fire4_squeeze_ofm_writer #(
    .WOUT(WOUT), .DSP_NO(DSP_NO), .WIDTH(WIDTH), .ADDR_W(ADDR_W)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .fire4_squeeze_sample (sample),
    .ofm_in               (ofm),
    .clear                (clear),
    .ram_we               (ram_we),
    .ram_addr             (ram_addr),
    .ram_wdata            (ram_wdata),
    .ram_feedback         (ram_feedback),
    .fmap_ready           (fmap_ready),
    .overflow             (overflow)
  );

  // Write tally, sampled mid-cycle while the registered port is stable.
  always @(negedge clk) if (rst && ram_we) wcount[ram_addr] = wcount[ram_addr] + 1;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_pix(input int a, input int b, input int c, input int d);
    ofm[0] = WIDTH'(a); ofm[1] = WIDTH'(b); ofm[2] = WIDTH'(c); ofm[3] = WIDTH'(d);
  endtask

  task automatic chk_wr(input string tag, input int addr, input int data);
    chk({tag, "_we"}, 32'(ram_we), 1);
    chk({tag, "_addr"}, 32'(ram_addr), addr);
    chk({tag, "_data"}, 32'(ram_wdata), data);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) wcount[i] = 0;
    set_pix(0, 0, 0, 0);

    // Reset state
    step(); step();
    chk("rst_we", 32'(ram_we), 0);
    chk("rst_addr", 32'(ram_addr), 0);
    chk("rst_wdata", 32'(ram_wdata), 0);
    chk("rst_fb", 32'(ram_feedback), 0);
    chk("rst_fr", 32'(fmap_ready), 0);
    chk("rst_ovf", 32'(overflow), 0);
    rst = 1'b1;
    step();

    // Single pixel 0
    sample = 1'b1; set_pix(10, 20, 30, 40);
    step(); sample = 1'b0;
    chk("p0_lat", 32'(ram_we), 0);
    step(); chk_wr("p0c0", 0, 10);
    step(); chk_wr("p0c1", 1, 20);
    step(); chk_wr("p0c2", 2, 30);
    step(); chk_wr("p0c3", 3, 40);
    step(); chk("p0_end", 32'(ram_we), 0);
    for (int i = 0; i < 4; i++) step();

    // Back-to-back pixels 1 and 2
    sample = 1'b1; set_pix(11, 21, 31, 41);
    step(); sample = 1'b0;
    step(); chk_wr("p1c0", 4, 11);
    step(); chk_wr("p1c1", 5, 21);
    step(); chk_wr("p1c2", 6, 31);
    sample = 1'b1; set_pix(12, 22, 32, 42);
    step(); sample = 1'b0;
    chk_wr("p1c3", 7, 41);
    step(); chk_wr("p2c0", 8, 12);
    step(); chk_wr("p2c1", 9, 22);
    step(); chk_wr("p2c2", 10, 32);
    step(); chk_wr("p2c3", 11, 42);
    chk("b2b_ovf", 32'(overflow), 0);
    step(); chk("p2_end", 32'(ram_we), 0);
    for (int i = 0; i < 6; i++) step();

    // Last pixel, layer completion
    sample = 1'b1; set_pix(13, 23, 33, 43);
    step(); sample = 1'b0;
    step(); chk_wr("p3c0", 12, 13);
    step(); chk_wr("p3c1", 13, 23);
    step(); chk_wr("p3c2", 14, 33);
    step(); chk_wr("p3c3", 15, 43);
    chk("p3c3_fb", 32'(ram_feedback), 0);
    step();
    chk("done_we", 32'(ram_we), 0);
    chk("done_fb", 32'(ram_feedback), 1);
    chk("done_fr", 32'(fmap_ready), 1);
    step();
    chk("done_fr_pulse", 32'(fmap_ready), 0);
    chk("done_fb_hold", 32'(ram_feedback), 1);
    for (int i = 0; i < 16; i++) chk($sformatf("wcount%0d", i), 32'(wcount[i]), 1);

    // Sample in DONE is dropped
    sample = 1'b1; set_pix(99, 99, 99, 99);
    step(); sample = 1'b0;
    chk("done_smp_we", 32'(ram_we), 0);
    step();
    chk("done_smp_we2", 32'(ram_we), 0);
    chk("done_smp_ovf", 32'(overflow), 1);
    chk("done_smp_fb", 32'(ram_feedback), 1);

    // clear re-arms; next pixel lands at address 0
    clear = 1'b1;
    step(); clear = 1'b0;
    step();
    chk("clr_fb", 32'(ram_feedback), 0);
    sample = 1'b1; set_pix(50, 60, 70, 80);
    step(); sample = 1'b0;
    step(); chk_wr("clr_c0", 0, 50);
    step(); chk_wr("clr_c1", 1, 60);
    step(); step(); step();

    // Asynchronous reset mid-write at ch=2
    sample = 1'b1; set_pix(1, 2, 3, 4);
    step(); sample = 1'b0;
    step(); step(); step();
    chk_wr("ar_c2", 6, 3);
    #2 rst = 1'b0;
    #1;
    chk("ar_we", 32'(ram_we), 0);
    chk("ar_ovf", 32'(overflow), 0);
    step(); rst = 1'b1;
    step();

    // After reset a sample writes from address 0; a sample on ch=1 is dropped
    for (int i = 0; i < 16; i++) wcount[i] = 0;
    sample = 1'b1; set_pix(91, 92, 93, 94);
    step(); sample = 1'b0;
    step(); chk_wr("rr_c0", 0, 91);
    sample = 1'b1; set_pix(7, 7, 7, 7);
    step(); sample = 1'b0;
    chk_wr("ov_c1", 1, 92);
    chk("ov_flag", 32'(overflow), 1);
    step(); chk_wr("ov_c2", 2, 93);
    step(); chk_wr("ov_c3", 3, 94);
    step(); chk("ov_no4", 32'(ram_we), 0);
    step(); step();
    chk("ov_wc4", 32'(wcount[4]), 0);
    chk("ov_sticky", 32'(overflow), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
